mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory (1-cycle read latency)
// between an instruction-fetch port and a data port. Grants are combinational, data
// wins contention by default, and a starvation counter forces an instruction grant
// once the fetch side has waited STARVE_LIMIT consecutive cycles.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN selects alternating priority under
// contention (starvation override still applies); undefined gives fixed data priority.

module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [15:0] i_rdata,

    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic [1:0]  d_we,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,

    output logic [15:0] m_addr,
    output logic        m_oe,
    output logic [1:0]  m_we,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata
);

    localparam logic [3:0] LimitW = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RET_NONE,
        RET_I,
        RET_D
    } ret_state_e;

    ret_state_e ret_q, ret_d;
    logic [3:0] starve_q, starve_d;
    logic       starved;
    logic       grant_i, grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 when the data port won the most recent grant
    logic last_d_q, last_d_d;
`endif

    assign starved = (starve_q >= LimitW);

    // Pick at most one requester; nothing is granted while in reset
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (starved) begin
                    grant_i = 1'b1;
                end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (last_d_q) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
`else
                    grant_d = 1'b1;
`endif
                end
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;

    // Steer the winner onto the memory bus; idle bus is all zeros
    always_comb begin
        m_addr  = '0;
        m_oe    = 1'b0;
        m_we    = 2'b00;
        m_wdata = '0;
        if (grant_i) begin
            m_addr = i_addr;
            m_oe   = 1'b1;
        end else if (grant_d) begin
            m_addr = d_addr;
            m_we   = d_we;
            m_oe   = (d_we == 2'b00);
            if (d_we != 2'b00) begin
                m_wdata = d_wdata;
            end
        end
    end

    // Next return owner and starvation count
    always_comb begin
        ret_d = RET_NONE;
        if (grant_i) begin
            ret_d = RET_I;
        end else if (grant_d && (d_we == 2'b00)) begin
            ret_d = RET_D;
        end

        starve_d = '0;
        if (i_req && !grant_i) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end
    end

    // Return tracker and starvation counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_q    <= RET_NONE;
            starve_q <= '0;
        end else begin
            ret_q    <= ret_d;
            starve_q <= starve_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember who won last; hold when idle
    always_comb begin
        last_d_d = last_d_q;
        if (grant_d) begin
            last_d_d = 1'b1;
        end else if (grant_i) begin
            last_d_d = 1'b0;
        end
    end

    // Last-winner flop, resets to instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`endif

    // Read returns come from the tracker state; masked during reset so a read
    // granted just before reset never returns
    assign i_rvalid = (ret_q == RET_I) && !rst;
    assign d_rvalid = (ret_q == RET_D) && !rst;
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: randomized and directed traffic against a
// behavioural arbitration model, with a scoreboard queue of expected read returns
// checked by an independent monitor.

module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid;
    logic [15:0] i_addr, i_rdata;
    logic        d_req, d_gnt, d_rvalid;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_we;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic        m_oe;
    logic [1:0]  m_we;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_addr   (m_addr),
        .m_oe     (m_oe),
        .m_we     (m_we),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503 + 12345);
    endfunction

    // Memory device: 1-cycle read latency, byte-enabled writes
    logic [15:0] mem [256];
    initial begin
        for (int a = 0; a < 256; a++) mem[a] = init_word(a);
        m_rdata = '0;
        forever begin
            @(posedge clk);
            if (m_oe) m_rdata <= mem[m_addr[7:0]];
            if (m_we[0]) mem[m_addr[7:0]][7:0]  <= m_wdata[7:0];
            if (m_we[1]) mem[m_addr[7:0]][15:8] <= m_wdata[15:8];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct {
        bit          is_d;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t        exp_q[$];
    logic [15:0] ref_mem [256];
    int          wait_i = 0;
    bit          last_d = 1'b0;
    bit          last_dg;

    // Pending requests; each held until granted
    bit          ip = 0, dp = 0;
    logic [15:0] ia = '0, da = '0, dwd = '0;
    logic [1:0]  dwe = '0;

    // Monitor: compare every cycle's read returns against the scoreboard
    initial begin
        forever begin
            bit ei, ed;
            logic [15:0] ev;
            @(negedge clk);
            #1;
            ei = 0; ed = 0; ev = '0;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("stale_return", 32'(exp_q[0].due), 32'(cyc));
                exp_q.delete(0);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                ei = !exp_q[0].is_d;
                ed = exp_q[0].is_d;
                ev = exp_q[0].data;
                exp_q.delete(0);
            end
            chk("i_rvalid", i_rvalid, ei);
            chk("d_rvalid", d_rvalid, ed);
            chk("i_rdata", i_rdata, ei ? ev : 16'h0);
            chk("d_rdata", d_rdata, ed ? ev : 16'h0);
        end
    end

    // Drive one cycle, then check grants and bus against the model
    task automatic step(input bit r);
        bit          eig, edg, eoe;
        logic [15:0] ea, ewd;
        logic [1:0]  ewe;
        exp_t        e;
        @(posedge clk);
        #1;
        rst = r; i_req = ip; i_addr = ia;
        d_req = dp; d_addr = da; d_we = dwe; d_wdata = dwd;
        // a read whose return falls in a reset cycle is dropped
        if (r) begin
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due == cyc)
                exp_q.delete(exp_q.size() - 1);
        end
        @(negedge clk);
        eig = 0; edg = 0;
        if (!r) begin
            if (ip && dp) begin
                if (wait_i >= int'(LIMIT)) eig = 1;
                else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (last_d) eig = 1; else edg = 1;
`else
                    edg = 1;
`endif
                end
            end else begin
                eig = ip;
                edg = dp;
            end
        end
        chk("i_gnt", i_gnt, eig);
        chk("d_gnt", d_gnt, edg);
        ea = '0; eoe = 0; ewe = 2'b00; ewd = '0;
        if (eig) begin
            ea = ia; eoe = 1;
            e.is_d = 0; e.data = ref_mem[ia[7:0]]; e.due = cyc + 1;
            exp_q.push_back(e);
        end else if (edg) begin
            ea = da; ewe = dwe; eoe = (dwe == 2'b00);
            if (dwe == 2'b00) begin
                e.is_d = 1; e.data = ref_mem[da[7:0]]; e.due = cyc + 1;
                exp_q.push_back(e);
            end else begin
                ewd = dwd;
                if (dwe[0]) ref_mem[da[7:0]][7:0]  = dwd[7:0];
                if (dwe[1]) ref_mem[da[7:0]][15:8] = dwd[15:8];
            end
        end
        chk("m_addr", m_addr, ea);
        chk("m_oe", m_oe, eoe);
        chk("m_we", m_we, ewe);
        chk("m_wdata", m_wdata, ewd);
        if (r) begin
            wait_i = 0;
            last_d = 0;
        end else begin
            wait_i = (ip && !eig) ? wait_i + 1 : 0;
            if (eig) last_d = 0;
            if (edg) last_d = 1;
        end
        last_dg = edg;
        if (eig) ip = 0;
        if (edg) dp = 0;
    endtask

    initial begin
        logic [7:0] gpat, gexp;
        rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_addr = '0; d_we = '0; d_wdata = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
        step(1);
        step(1);

        // Store 0xA5A5 at 0x0010, then fetch it
        dp = 1; da = 16'h0010; dwe = 2'b11; dwd = 16'hA5A5; step(0);
        ip = 1; ia = 16'h0010; step(0);
        step(0);

        // Low-byte store
        dp = 1; da = 16'h0020; dwe = 2'b01; dwd = 16'h00CC; step(0);
        step(0);

        // Both requesters held for 8 cycles from a clean reset
        step(1);
        gpat = '0;
        for (int k = 0; k < 8; k++) begin
            ip = 1; ia = 16'($urandom);
            dp = 1; da = 16'($urandom); dwe = 2'b00;
            step(0);
            gpat[k] = last_dg;
        end
        ip = 0; dp = 0;
        step(0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        gexp = 8'b0101_0101;
`else
        gexp = 8'b1110_1111;
`endif
        chk("contention_pattern", gpat, gexp);

        // Alternating instruction and data reads
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                ip = 1; ia = 16'($urandom);
            end else begin
                dp = 1; da = 16'($urandom); dwe = 2'b00;
            end
            step(0);
        end

        // Data read immediately followed by reset
        dp = 1; da = 16'h0033; dwe = 2'b00; step(0);
        step(1);
        step(1);
        step(0);

        // Random traffic with occasional resets
        for (int n = 0; n < 500; n++) begin
            if (!ip && ($urandom_range(0, 2) != 0)) begin
                ip = 1; ia = 16'($urandom);
            end
            if (!dp && ($urandom_range(0, 2) != 0)) begin
                dp = 1; da = 16'($urandom); dwd = 16'($urandom);
                dwe = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            end
            step($urandom_range(0, 59) == 0);
        end
        ip = 0; dp = 0;
        step(0);
        step(0);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
